// File: rtl/ccc_lock_sequencer_if.sv
// ccc_lock_sequencer_if
//   Groups the lock inputs, the soft-restart request and the supervised
//   reset/status outputs of ccc_lock_sequencer.
//   master : lock source / supervisor side (drives FAB_LOCK, MSS_LOCK, SOFT_RST_REQ)
//   slave  : ccc_lock_sequencer (drives RST_OUT_N, READY, LOCK_TIMEOUT, LOSS_COUNT, STATE)
interface ccc_lock_sequencer_if #(
  parameter int unsigned NUM_RST_OUT = 3,
  parameter int unsigned LOSS_CNT_W  = 8
);
  logic                   FAB_LOCK;
  logic                   MSS_LOCK;
  logic                   SOFT_RST_REQ;
  logic [NUM_RST_OUT-1:0] RST_OUT_N;
  logic                   READY;
  logic                   LOCK_TIMEOUT;
  logic [LOSS_CNT_W-1:0]  LOSS_COUNT;
  logic [2:0]             STATE;

  modport master (
    output FAB_LOCK, MSS_LOCK, SOFT_RST_REQ,
    input  RST_OUT_N, READY, LOCK_TIMEOUT, LOSS_COUNT, STATE
  );

  modport slave (
    input  FAB_LOCK, MSS_LOCK, SOFT_RST_REQ,
    output RST_OUT_N, READY, LOCK_TIMEOUT, LOSS_COUNT, STATE
  );
endinterface

// File: rtl/ccc_lock_sequencer.sv
// ccc_lock_sequencer
//   Supervises the CCC clock path: synchronises and ANDs FAB_LOCK/MSS_LOCK,
//   requires an uninterrupted stable-lock window, then releases the fabric
//   reset domains one by one (bit 0 first), STAGE_GAP_CYCLES apart, and
//   raises READY one gap after the last release. Lock loss re-asserts every
//   domain reset and bumps a saturating loss counter; never seeing lock
//   within the timeout latches LOCK_TIMEOUT until SOFT_RST_REQ or reset.
// Ports
//   FAB_CLK      in  fabric clock
//   M2F_RESET_N  in  asynchronous active-low reset
//   bus          slave modport of ccc_lock_sequencer_if (locks, soft request,
//                RST_OUT_N, READY, LOCK_TIMEOUT, LOSS_COUNT, STATE)
module ccc_lock_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned NUM_RST_OUT         = 3,
  parameter int unsigned STAGE_GAP_CYCLES    = 16,
  parameter int unsigned CNT_W               = 20,
  parameter int unsigned LOSS_CNT_W          = 8
) (
  input  logic                 FAB_CLK,
  input  logic                 M2F_RESET_N,
  ccc_lock_sequencer_if.slave  bus
);

  localparam int unsigned GAP_W = (STAGE_GAP_CYCLES > 1) ? $clog2(STAGE_GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABILIZE  = 3'd2,
    RELEASE    = 3'd3,
    RUN        = 3'd4,
    FAULT      = 3'd5
  } state_t;

  state_t                 r_state;
  logic                   r_fab_meta, r_fab_sync;
  logic                   r_mss_meta, r_mss_sync;
  logic [CNT_W-1:0]       r_tcnt;
  logic [CNT_W-1:0]       r_scnt;
  logic [GAP_W-1:0]       r_gap;
  logic [NUM_RST_OUT-1:0] r_rst_n;
  logic                   r_ready;
  logic                   r_timeout;
  logic [LOSS_CNT_W-1:0]  r_loss;

  logic                   w_lock_ok;
  logic                   w_tcnt_last;
  logic [CNT_W-1:0]       w_tcnt_inc;

  assign w_lock_ok   = r_fab_sync & r_mss_sync;
  assign w_tcnt_last = (r_tcnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1));
  // Timeout counter saturates so repeated STABILIZE/WAIT_LOCK bouncing can
  // never wrap past the terminal value and miss the fault.
  assign w_tcnt_inc  = w_tcnt_last ? r_tcnt : r_tcnt + CNT_W'(1);

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      r_state    <= RESET_HOLD;
      r_fab_meta <= 1'b0;
      r_fab_sync <= 1'b0;
      r_mss_meta <= 1'b0;
      r_mss_sync <= 1'b0;
      r_tcnt     <= '0;
      r_scnt     <= '0;
      r_gap      <= '0;
      r_rst_n    <= '0;
      r_ready    <= 1'b0;
      r_timeout  <= 1'b0;
      r_loss     <= '0;
    end else begin
      r_fab_meta <= bus.FAB_LOCK;
      r_fab_sync <= r_fab_meta;
      r_mss_meta <= bus.MSS_LOCK;
      r_mss_sync <= r_mss_meta;

      case (r_state)
        RESET_HOLD: begin
          r_tcnt  <= '0;
          r_scnt  <= '0;
          r_gap   <= '0;
          r_rst_n <= '0;
          r_ready <= 1'b0;
          r_state <= WAIT_LOCK;
        end

        WAIT_LOCK: begin
          if (bus.SOFT_RST_REQ) begin
            r_rst_n <= '0;
            r_ready <= 1'b0;
            r_state <= RESET_HOLD;
          end else begin
            r_tcnt <= w_tcnt_inc;
            if (w_lock_ok) begin
              r_scnt  <= '0;
              r_state <= STABILIZE;
            end else if (w_tcnt_last) begin
              r_timeout <= 1'b1;
              r_state   <= FAULT;
            end
          end
        end

        STABILIZE: begin
          if (bus.SOFT_RST_REQ) begin
            r_rst_n <= '0;
            r_ready <= 1'b0;
            r_state <= RESET_HOLD;
          end else if (!w_lock_ok) begin
            r_tcnt  <= w_tcnt_inc;
            r_state <= WAIT_LOCK;
          end else if (r_scnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
            r_rst_n <= NUM_RST_OUT'(1);
            r_gap   <= '0;
            r_state <= RELEASE;
          end else begin
            r_tcnt <= w_tcnt_inc;
            r_scnt <= r_scnt + CNT_W'(1);
          end
        end

        RELEASE, RUN: begin
          // Lock loss takes priority over a coincident soft request so the
          // event is always counted.
          if (!w_lock_ok) begin
            r_rst_n <= '0;
            r_ready <= 1'b0;
            r_tcnt  <= '0;
            if (r_loss != '1) r_loss <= r_loss + LOSS_CNT_W'(1);
            r_state <= WAIT_LOCK;
          end else if (bus.SOFT_RST_REQ) begin
            r_rst_n <= '0;
            r_ready <= 1'b0;
            r_state <= RESET_HOLD;
          end else if (r_state == RELEASE) begin
            if (r_gap == GAP_W'(STAGE_GAP_CYCLES - 1)) begin
              r_gap <= '0;
              if (&r_rst_n) begin
                r_ready <= 1'b1;
                r_state <= RUN;
              end else begin
                r_rst_n <= (r_rst_n << 1) | NUM_RST_OUT'(1);
              end
            end else begin
              r_gap <= r_gap + GAP_W'(1);
            end
          end
        end

        FAULT: begin
          r_rst_n <= '0;
          r_ready <= 1'b0;
          if (bus.SOFT_RST_REQ) begin
            r_timeout <= 1'b0;
            r_state   <= RESET_HOLD;
          end
        end

        default: begin
          r_rst_n <= '0;
          r_ready <= 1'b0;
          r_state <= RESET_HOLD;
        end
      endcase
    end
  end

  assign bus.RST_OUT_N    = r_rst_n;
  assign bus.READY        = r_ready;
  assign bus.LOCK_TIMEOUT = r_timeout;
  assign bus.LOSS_COUNT   = r_loss;
  assign bus.STATE        = r_state;

endmodule
